// File: rtl/mdu_pkg.sv
// mdu_pkg: MDOp encodings and FSM state type shared by the mdu, decoder and hazard unit.
package mdu_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;
  typedef enum logic {S_IDLE, S_BUSY} md_state_e;
endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] Data1;
  logic [31:0] Data2;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, MDOp, Data1, Data2, input busy, HI, LO);
  modport slave  (input start, MDOp, Data1, Data2, output busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational next HI/LO for every MDOp, including the divide-by-zero hold.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] pend_hi_o,
  output logic [31:0] pend_lo_o
);
  logic [63:0] sprod, uprod, prod;
  logic        sdiv, zero;
  logic [31:0] ma, mb, mq, mr, q, r;
  assign sprod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uprod = {32'b0, a_i} * {32'b0, b_i};
  assign prod  = md_op_i[0] ? uprod : sprod;
  // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  assign sdiv  = !md_op_i[0];
  assign zero  = b_i == 32'd0;
  assign ma    = (sdiv && a_i[31]) ? -a_i : a_i;
  assign mb    = (sdiv && b_i[31]) ? -b_i : b_i;
  assign mq    = zero ? 32'd0 : ma / mb;
  assign mr    = zero ? 32'd0 : ma % mb;
  assign q     = (sdiv && (a_i[31] ^ b_i[31])) ? -mq : mq;
  assign r     = (sdiv && a_i[31]) ? -mr : mr;
  assign pend_hi_o = md_op_i[2] ? (md_op_i == MD_MTHI ? a_i : hi_i)
                   : md_op_i[1] ? (zero ? hi_i : r) : prod[63:32];
  assign pend_lo_o = md_op_i[2] ? (md_op_i == MD_MTLO ? a_i : lo_i)
                   : md_op_i[1] ? (zero ? lo_i : q) : prod[31:0];
endmodule

// File: rtl/mdu.sv
// mdu: fixed-latency multiply/divide unit owning HI/LO; result is computed at issue and
// committed when the busy countdown expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave md
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, pend_hi_q, pend_lo_q, pend_hi_d, pend_lo_d;
  mdu_calc u_calc (
    .md_op_i  (md.MDOp),
    .a_i      (md.Data1),
    .b_i      (md.Data2),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .pend_hi_o(pend_hi_d),
    .pend_lo_o(pend_lo_d)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (md.start && !md.MDOp[2]) begin
        state_q   <= S_BUSY;
        busy_q    <= 1'b1;
        cnt_q     <= md.MDOp[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
        pend_hi_q <= pend_hi_d;
        pend_lo_q <= pend_lo_d;
      end else if (md.start) begin
        hi_q <= pend_hi_d;
        lo_q <= pend_lo_d;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end else begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= pend_hi_q;
      lo_q    <= pend_lo_q;
    end
  end
  assign md.busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against a 64-bit arithmetic reference model.
module tb_mdu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  mdu_if bus();
  mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint q, r;
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2, 3'd3: begin
        if (b == 0) return {hi, lo};
        q = op[0] ? ua / ub : sa / sb;
        r = op[0] ? ua % ub : sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, input bit hold, input bit wiggle);
    logic [63:0] e = model(op, a, b, hi_m, lo_m);
    int n = op[2] ? 0 : (op[1] ? 10 : 5);
    int cyc = 0;
    bus.start = 1'b1;
    bus.MDOp  = op;
    bus.Data1 = a;
    bus.Data2 = b;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    if (wiggle) begin
      bus.Data1 = ~a;
      bus.Data2 = b + 32'd7;
    end
    if (n > 0) begin
      check("busy_rise", 32'(bus.busy), 32'd1);
      check("hi_held", bus.HI, hi_m);
      check("lo_held", bus.LO, lo_m);
      while (bus.busy && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("busy_cycles", 32'(cyc), 32'(n));
    end else begin
      check("busy_mt", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    hi_m = e[63:32];
    lo_m = e[31:0];
    check("hi", bus.HI, hi_m);
    check("lo", bus.LO, lo_m);
    if (hold) begin
      @(posedge clk); #1;
      check("hold_no_reissue", 32'(bus.busy), 32'd0);
      check("hold_hi", bus.HI, hi_m);
    end
  endtask

  initial begin
    logic [31:0] b;
    bus.start = 1'b0;
    bus.MDOp  = '0;
    bus.Data1 = '0;
    bus.Data2 = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_hi", bus.HI, 32'd0);
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("mult_hi_c", bus.HI, 32'hFFFFFFFF);
    check("mult_lo_c", bus.LO, 32'hFFFFFFFA);
    do_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("multu_hi_c", bus.HI, 32'h00000002);
    check("multu_lo_c", bus.LO, 32'hFFFFFFFA);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_lo_c", bus.LO, 32'hFFFFFFFD);
    check("div_hi_c", bus.HI, 32'hFFFFFFFF);
    do_op(3'd3, 32'd7, 32'd2, 0, 0);
    check("divu_lo_c", bus.LO, 32'd3);
    check("divu_hi_c", bus.HI, 32'd1);
    do_op(3'd4, 32'h11, 32'd0, 0, 0);
    do_op(3'd5, 32'h22, 32'd0, 0, 0);
    do_op(3'd2, 32'd99, 32'd0, 0, 0);
    check("div0_hi_c", bus.HI, 32'h11);
    check("div0_lo_c", bus.LO, 32'h22);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("ovf_lo_c", bus.LO, 32'h80000000);
    check("ovf_hi_c", bus.HI, 32'd0);
    do_op(3'd4, 32'hDEADBEEF, 32'd0, 0, 0);
    do_op(3'd5, 32'h12345678, 32'd0, 0, 0);
    check("mt_hi_c", bus.HI, 32'hDEADBEEF);
    check("mt_lo_c", bus.LO, 32'h12345678);
    do_op(3'd6, 32'hAAAA5555, 32'd1, 0, 0);
    do_op(3'd7, 32'h5555AAAA, 32'd1, 0, 0);
    do_op(3'd0, 32'd1234567, 32'd89, 1, 0);
    do_op(3'd1, 32'hCAFEF00D, 32'h13579BDF, 0, 1);
    do_op(3'd2, 32'h87654321, 32'd1000, 0, 1);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op(3'($urandom_range(0, 7)), $urandom, b, 0, $urandom_range(0, 1) == 1);
    end
    do_op(3'd4, 32'h5, 32'd0, 0, 0);
    bus.start = 1'b1;
    bus.MDOp  = 3'd2;
    bus.Data1 = 32'd100;
    bus.Data2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_hi", bus.HI, 32'd0);
    check("arst_lo", bus.LO, 32'd0);
    #1 reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (12) @(posedge clk);
    #1;
    check("arst_after_busy", 32'(bus.busy), 32'd0);
    check("arst_after_lo", bus.LO, 32'd0);
    do_op(3'd3, 32'd1000, 32'd7, 0, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
